// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Central hazard unit for the five-stage MIPS pipeline.
//   * Data hazards: compares the D-stage source registers and their Tuse tags
//     against the destinations and Tnew tags of the E and M stages. A stall
//     holds the PC and the F->D register and bubbles the D->E register.
//   * Forwarding: selects the bypass source for the D-stage comparator/branch
//     operands and for the E-stage ALU operands.
//   * Mult/div: a down-counter models the multi-cycle HI/LO unit. While it
//     runs, any D instruction that touches HI/LO is stalled.
//
// Parameters
//   MULT_CYCLES  busy cycles after an accepted mult/multu
//   DIV_CYCLES   busy cycles after an accepted div/divu
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   Rs_D, Rt_D               D-stage source registers
//   Tuse_rs_D, Tuse_rt_D     0 = read in D, 1 = read in E, 3 = not read
//   Rs_E, Rt_E               source registers held in the D->E register
//   WA_E/RegWrite_E/Tnew_E   E-stage destination, write enable, cycles to result
//   WA_M/RegWrite_M/Tnew_M   M-stage destination, write enable, cycles to result
//   WA_W/RegWrite_W          W-stage destination, write enable
//   md_start_D, md_is_div_D  D instruction is mult/div (and which one)
//   md_use_D                 D instruction touches HI/LO
//   stall_F, stall_D, clr_E  stall the front end, bubble the D->E register
//   fwd_rs_D, fwd_rt_D       00 reg file, 01 from M, 10 from W, 11 from E
//   fwd_rs_E, fwd_rt_E       00 pipe value, 01 from M, 10 from W
//   md_busy                  mult/div unit busy
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WA_E,
  input  logic       RegWrite_E,
  input  logic [1:0] Tnew_E,
  input  logic [4:0] WA_M,
  input  logic       RegWrite_M,
  input  logic [1:0] Tnew_M,
  input  logic [4:0] WA_W,
  input  logic       RegWrite_W,
  input  logic       md_start_D,
  input  logic       md_is_div_D,
  input  logic       md_use_D,
  output logic       stall_F,
  output logic       stall_D,
  output logic       clr_E,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       md_busy
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register file / value already in the pipe register
    FWD_M  = 2'b01,
    FWD_W  = 2'b10,
    FWD_E  = 2'b11   // only meaningful for the D-stage selects
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Counter must hold the longer of the two latencies, and is never below 4 bits.
  localparam int MD_MAX    = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MD_BITS   = $clog2(MD_MAX + 1);
  localparam int CNT_W     = (MD_BITS > 4) ? MD_BITS : 4;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  // A source hits a stage only when that stage really writes a non-$0 register.
  function automatic logic reg_hit(input logic [4:0] src,
                                   input logic [4:0] wa,
                                   input logic       we);
    return we && (wa != 5'd0) && (src == wa);
  endfunction

  // The consumer needs the value before the producer has it: stall.
  function automatic logic use_too_early(input logic [1:0] tuse,
                                         input logic       hit_e,
                                         input logic       hit_m,
                                         input logic [1:0] tnew_e,
                                         input logic [1:0] tnew_m);
    return (tuse != TUSE_NONE) &&
           ((hit_e && (tuse < tnew_e)) || (hit_m && (tuse < tnew_m)));
  endfunction

  // D-stage bypass: youngest producer whose value already exists wins.
  function automatic fwd_sel_e fwd_sel_d(input logic       hit_e,
                                         input logic       hit_m,
                                         input logic       hit_w,
                                         input logic [1:0] tnew_e,
                                         input logic [1:0] tnew_m);
    if (hit_e && (tnew_e == 2'd0))      return FWD_E;
    else if (hit_m && (tnew_m == 2'd0)) return FWD_M;
    else if (hit_w)                     return FWD_W;
    else                                return FWD_RF;
  endfunction

  // E-stage bypass: the E stage cannot forward to itself.
  function automatic fwd_sel_e fwd_sel_e_stage(input logic       hit_m,
                                               input logic       hit_w,
                                               input logic [1:0] tnew_m);
    if (hit_m && (tnew_m == 2'd0)) return FWD_M;
    else if (hit_w)                return FWD_W;
    else                           return FWD_RF;
  endfunction

  // ---------------------------------------------------------------------------
  // Register match bits
  // ---------------------------------------------------------------------------
  logic rs_d_hit_e, rs_d_hit_m, rs_d_hit_w;
  logic rt_d_hit_e, rt_d_hit_m, rt_d_hit_w;
  logic rs_e_hit_m, rs_e_hit_w;
  logic rt_e_hit_m, rt_e_hit_w;

  assign rs_d_hit_e = reg_hit(Rs_D, WA_E, RegWrite_E);
  assign rs_d_hit_m = reg_hit(Rs_D, WA_M, RegWrite_M);
  assign rs_d_hit_w = reg_hit(Rs_D, WA_W, RegWrite_W);
  assign rt_d_hit_e = reg_hit(Rt_D, WA_E, RegWrite_E);
  assign rt_d_hit_m = reg_hit(Rt_D, WA_M, RegWrite_M);
  assign rt_d_hit_w = reg_hit(Rt_D, WA_W, RegWrite_W);
  assign rs_e_hit_m = reg_hit(Rs_E, WA_M, RegWrite_M);
  assign rs_e_hit_w = reg_hit(Rs_E, WA_W, RegWrite_W);
  assign rt_e_hit_m = reg_hit(Rt_E, WA_M, RegWrite_M);
  assign rt_e_hit_w = reg_hit(Rt_E, WA_W, RegWrite_W);

  // ---------------------------------------------------------------------------
  // Stall generation
  // ---------------------------------------------------------------------------
  logic stall_rs, stall_rt, stall_md, stall;

  assign stall_rs = use_too_early(Tuse_rs_D, rs_d_hit_e, rs_d_hit_m, Tnew_E, Tnew_M);
  assign stall_rt = use_too_early(Tuse_rt_D, rt_d_hit_e, rt_d_hit_m, Tnew_E, Tnew_M);
  assign stall_md = md_use_D & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  // Freezing F/D and bubbling E are always the same decision.
  assign stall_F = stall;
  assign stall_D = stall;
  assign clr_E   = stall;

  // ---------------------------------------------------------------------------
  // Forwarding selects
  // ---------------------------------------------------------------------------
  assign fwd_rs_D = fwd_sel_d(rs_d_hit_e, rs_d_hit_m, rs_d_hit_w, Tnew_E, Tnew_M);
  assign fwd_rt_D = fwd_sel_d(rt_d_hit_e, rt_d_hit_m, rt_d_hit_w, Tnew_E, Tnew_M);
  assign fwd_rs_E = fwd_sel_e_stage(rs_e_hit_m, rs_e_hit_w, Tnew_M);
  assign fwd_rt_E = fwd_sel_e_stage(rt_e_hit_m, rt_e_hit_w, Tnew_M);

  // ---------------------------------------------------------------------------
  // Mult/div busy tracking
  // ---------------------------------------------------------------------------
  md_state_e        md_state_q, md_state_d;
  logic [CNT_W-1:0] md_cnt_q,   md_cnt_d;
  logic             md_accept;
  logic [CNT_W-1:0] md_load;

  // A start held in D by any stall has not issued, so it must not load.
  assign md_accept = md_start_D & ~stall;
  assign md_load   = md_is_div_D ? DIV_LOAD : MULT_LOAD;

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (md_accept) begin
          md_cnt_d   = md_load;
          md_state_d = (md_load != CNT_ZERO) ? MD_BUSY : MD_IDLE;
        end
      end
      MD_BUSY: begin
        // Legal code cannot start while busy (the start itself stalls), but a
        // start that does get through reloads rather than being dropped.
        if (md_accept) begin
          md_cnt_d   = md_load;
          md_state_d = (md_load != CNT_ZERO) ? MD_BUSY : MD_IDLE;
        end else if (md_cnt_q <= CNT_ONE) begin
          md_cnt_d   = CNT_ZERO;
          md_state_d = MD_IDLE;
        end else begin
          md_cnt_d   = md_cnt_q - CNT_ONE;
        end
      end
      default: begin
        md_cnt_d   = CNT_ZERO;
        md_state_d = MD_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and wins over a same-cycle start.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= CNT_ZERO;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != CNT_ZERO);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard unit for the five-stage MIPS pipeline: drives the stall enables for the F/D registers and the `clr_E` bubble input of the D→E register, and generates the forwarding mux selects for the D and E stages. It also owns a cycle counter that models the multi-cycle mult/div unit, so HI/LO consumers stall until the result is ready. Data-hazard decisions are combinational from per-stage Tuse/Tnew tags. The mult/div busy tracking is sequential.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu is accepted.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu is accepted.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `Rs_D`, `Rt_D`  in  5 each  source registers of the D-stage instruction
- `Tuse_rs_D`, `Tuse_rt_D`  in  2 each  0 = read in D, 1 = read in E, 3 = unused
- `Rs_E`, `Rt_E`  in  5 each  source registers held in the D→E register
- `WA_E`, `RegWrite_E`, `Tnew_E`  in  5/1/2  E-stage destination, write enable, cycles until result (0 = link value, 1 = ALU, 2 = load)
- `WA_M`, `RegWrite_M`, `Tnew_M`  in  5/1/2  M-stage equivalents (`Tnew_M` in {0,1})
- `WA_W`, `RegWrite_W`  in  5/1  W-stage destination and write enable
- `md_start_D`  in  1  D instruction is mult/multu/div/divu
- `md_is_div_D`  in  1  qualifies `md_start_D` (1 = div)
- `md_use_D`  in  1  D instruction touches HI/LO (mf*, mt*, mult, div)
- `stall_F`, `stall_D`  out  1 each  hold the PC and the F→D register
- `clr_E`  out  1  insert a bubble into the D→E register
- `fwd_rs_D`, `fwd_rt_D`  out  2 each  00 reg file, 01 from M, 10 from W, 11 from E
- `fwd_rs_E`, `fwd_rt_E`  out  2 each  00 pipe value, 01 from M, 10 from W
- `md_busy`  out  1  mult/div unit busy

## Operation
- **Match rule.** `X` matches stage S iff `X == WA_S`, `WA_S != 0` and `RegWrite_S`.
- **Data stall.**
  - `stall_rs` is asserted on either condition:
    - `Tuse_rs_D != 3`, `Rs_D` matches E, and `Tuse_rs_D < Tnew_E`;
    - `Tuse_rs_D != 3`, `Rs_D` matches M, and `Tuse_rs_D < Tnew_M`.
  - `stall_rt` uses the same rule with `Rt_D` and `Tuse_rt_D`.
- **MD stall.** `stall_md = md_use_D & md_busy`.
- **Combined stall.** `stall = stall_rs | stall_rt | stall_md`.
  - `stall_F = stall_D = clr_E = stall`.
- **D forwarding** (first match wins):
  1. E match with `Tnew_E == 0` → 11;
  2. M match with `Tnew_M == 0` → 01;
  3. W match → 10;
  4. otherwise → 00.
- **E forwarding** (first match wins):
  1. M match with `Tnew_M == 0` → 01;
  2. W match → 10;
  3. otherwise → 00.
- **MD counter** (`md_cnt`, 4 bits minimum, sized for `DIV_CYCLES`):
  - A start is accepted on the rising edge where `md_start_D & ~stall`.
  - On acceptance, `md_cnt` loads `DIV_CYCLES` if `md_is_div_D`, else `MULT_CYCLES`.
  - Otherwise, if `md_cnt != 0`, it decrements by 1.
  - `md_busy = (md_cnt != 0)`.
  - States: IDLE (cnt = 0) and BUSY (cnt > 0).
    - IDLE → BUSY on an accepted start.
    - BUSY → IDLE when the count reaches 0.
  - A second start cannot be accepted while BUSY, because `md_start_D` implies `md_use_D`, which stalls.
- **Stalled starts.** A start held by a data stall is not accepted, and the counter does not load.

## Timing
- **Reset.** `md_cnt` = 0 on the first edge with `reset` high, which gives:
  - `md_busy` = 0;
  - with inputs all 0: `stall_F`/`stall_D`/`clr_E` = 0 and every fwd select = 00.
- **Combinational outputs.** Stall and forward outputs are combinational, valid in the same cycle as their inputs. No latency.
- **Busy window.** After acceptance at edge k, `md_busy` is high for exactly N cycles (edges k+1 … k+N) and low after edge k+N.
  - A dependent mfhi in D stalls N cycles and proceeds in the cycle `md_busy` falls.
- **Reset mid-operation.** `reset` during BUSY clears the counter at that edge. Reset has priority over a simultaneous start.
- **Register 0.** `$0` never matches, so there is no stall and no forwarding for it.

## Test plan
- **Load-use.** `Rs_D`=8, `Tuse_rs_D`=0, E: `WA_E`=8, `RegWrite_E`=1, `Tnew_E`=2 → `stall_F`=`stall_D`=`clr_E`=1.
  - Next cycle, same register in M with `Tnew_M`=1 → stall=1.
  - Then `Tnew_M`=0 → stall=0, `fwd_rs_D`=01.
- **ALU to E-use.** `Tuse_rt_D`=1, `Rt_D`=9 matches E with `Tnew_E`=1 → no stall.
  - In E, `Rt_E`=9 matches M with `Tnew_M`=0 → `fwd_rt_E`=01.
  - A W match alone → 10.
- **Priority and `$0`.** `Rs_D`=5 matches E (`Tnew_E`=0), M and W → `fwd_rs_D`=11.
  - With `Rs_D`=0 and `WA_E`=0 → 00, no stall.
- **Div then mfhi.**
  - Accept div (`md_start_D`=1, `md_is_div_D`=1) → `md_busy` high for 10 cycles.
  - mfhi (`md_use_D`=1) in D next cycle → stall for 10 cycles, released on the 11th.
- **Mult with data stall.**
  - mult held by a data stall for 2 cycles → counter stays 0 during the stall.
  - On acceptance, `md_busy` is high for exactly 5 cycles.
- **Reset mid-busy.** Assert `reset` for one cycle at cnt=6 → `md_busy`=0 next cycle, and a pending mfhi is released.
